// File: rtl/add_fu_arbiter.sv
// add_fu_arbiter: round-robin arbiter in front of one shared adder.
// Winner operands are registered into S1 and drive the external adder.
// S2 captures the sum, later stages shift it toward the writeback bus.
// All stages stall together when the writeback bus withholds ready.
module add_fu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int TAG_W   = 5,
    parameter int LAT     = 2,
    localparam int SRC_W  = $clog2(NUM_REQ),
    localparam int CNT_W  = $clog2(LAT + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    input  logic                     flush,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    input  logic [WIDTH-1:0]         add_sum,
    output logic                     cdb_valid,
    input  logic                     cdb_ready,
    output logic [WIDTH-1:0]         cdb_result,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [SRC_W-1:0]         cdb_src,
    output logic                     busy,
    output logic [CNT_W-1:0]         inflight
);

    // Stage valids; index 0 is S1, index LAT-1 is the stage facing the bus
    logic [LAT-1:0]   valid_q, valid_d;

    // S1 operands, which are also the adder inputs
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;

    // Per-stage tag and source port; sums only exist from S2 onward
    logic [TAG_W-1:0] tag_q [LAT];
    logic [TAG_W-1:0] tag_d [LAT];
    logic [SRC_W-1:0] src_q [LAT];
    logic [SRC_W-1:0] src_d [LAT];
    logic [WIDTH-1:0] res_q [1:LAT-1];
    logic [WIDTH-1:0] res_d [1:LAT-1];

    // Round-robin pointer: last accepted port
    logic [SRC_W-1:0] rr_q, rr_d;

    // Registered popcount of stage valids
    logic [CNT_W-1:0] inflight_q, inflight_d;

    logic             advance;
    logic             accept;
    logic             grant_found;
    logic [SRC_W-1:0] grant_idx;
    int               search_idx;
    int               valid_cnt;

    // Whole pipeline moves only when the output stage is empty or being drained
    always_comb begin
        advance = !valid_q[LAT-1] || cdb_ready;
    end

    // Search for the first valid request starting just after the last winner
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        search_idx  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            search_idx = (int'(rr_q) + k) % NUM_REQ;
            if (!grant_found && req_valid[search_idx]) begin
                grant_found = 1'b1;
                grant_idx   = SRC_W'(search_idx);
            end
        end
    end

    // Grant is suppressed during reset, stalls and flush; accept mirrors it
    always_comb begin
        accept    = grant_found && advance && !flush;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = rst_n && accept && (grant_idx == SRC_W'(i));
        end
    end

    // Next-state for the pipeline registers and the round-robin pointer
    always_comb begin
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        tag_d   = tag_q;
        src_d   = src_q;
        res_d   = res_q;
        rr_d    = rr_q;

        if (advance) begin
            valid_d[0] = accept;
            if (accept) begin
                a_d      = req_a[grant_idx*WIDTH +: WIDTH];
                b_d      = req_b[grant_idx*WIDTH +: WIDTH];
                tag_d[0] = req_tag[grant_idx*TAG_W +: TAG_W];
                src_d[0] = grant_idx;
                rr_d     = grant_idx;
            end

            valid_d[1] = valid_q[0];
            res_d[1]   = add_sum;
            tag_d[1]   = tag_q[0];
            src_d[1]   = src_q[0];

            for (int s = 2; s < LAT; s++) begin
                valid_d[s] = valid_q[s-1];
                res_d[s]   = res_q[s-1];
                tag_d[s]   = tag_q[s-1];
                src_d[s]   = src_q[s-1];
            end
        end

        if (flush) begin
            valid_d = '0;
        end
    end

    // Occupancy count follows the next-state valids so it lines up with them
    always_comb begin
        valid_cnt = 0;
        for (int s = 0; s < LAT; s++) begin
            valid_cnt = valid_cnt + int'(valid_d[s]);
        end
        inflight_d = CNT_W'(valid_cnt);
    end

    // State registers; pointer resets so that port 0 wins the first search
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rr_q       <= SRC_W'(NUM_REQ - 1);
            inflight_q <= '0;
            for (int s = 0; s < LAT; s++) begin
                tag_q[s] <= '0;
                src_q[s] <= '0;
            end
            for (int s = 1; s < LAT; s++) begin
                res_q[s] <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rr_q       <= rr_d;
            inflight_q <= inflight_d;
            for (int s = 0; s < LAT; s++) begin
                tag_q[s] <= tag_d[s];
                src_q[s] <= src_d[s];
            end
            for (int s = 1; s < LAT; s++) begin
                res_q[s] <= res_d[s];
            end
        end
    end

    // Outputs come straight from registers
    always_comb begin
        add_a      = a_q;
        add_b      = b_q;
        cdb_valid  = valid_q[LAT-1];
        cdb_result = res_q[LAT-1];
        cdb_tag    = tag_q[LAT-1];
        cdb_src    = src_q[LAT-1];
        busy       = |valid_q;
        inflight   = inflight_q;
    end

endmodule

// File: tb/tb_add_fu_arbiter.sv
// tb_add_fu_arbiter: directed bench for the shared-adder arbiter.
// A behavioural adder closes the add_a/add_b -> add_sum loop.
module tb_add_fu_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 32;
    localparam int TAG_W   = 5;
    localparam int LAT     = 2;
    localparam int SRC_W   = 2;
    localparam int CNT_W   = 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ*TAG_W-1:0] req_tag;
    logic                     flush;
    logic [WIDTH-1:0]         add_a;
    logic [WIDTH-1:0]         add_b;
    logic [WIDTH-1:0]         add_sum;
    logic                     cdb_valid;
    logic                     cdb_ready;
    logic [WIDTH-1:0]         cdb_result;
    logic [TAG_W-1:0]         cdb_tag;
    logic [SRC_W-1:0]         cdb_src;
    logic                     busy;
    logic [CNT_W-1:0]         inflight;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        int               port;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] sum;
    } vec_t;

    vec_t vecs [6];

    add_fu_arbiter #(
        .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .TAG_W(TAG_W), .LAT(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .flush(flush),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .cdb_valid(cdb_valid), .cdb_ready(cdb_ready),
        .cdb_result(cdb_result), .cdb_tag(cdb_tag), .cdb_src(cdb_src),
        .busy(busy), .inflight(inflight)
    );

    // External adder model
    assign add_sum = add_a + add_b;

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic rdy,
                                 input logic fl);
        req_valid = valid;
        cdb_ready = rdy;
        flush     = fl;
        #1;
    endtask

    task automatic setPort(input int p, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag);
        req_a[p*WIDTH +: WIDTH]   = a;
        req_b[p*WIDTH +: WIDTH]   = b;
        req_tag[p*TAG_W +: TAG_W] = tag;
    endtask

    task automatic loadStreamData();
        for (int i = 0; i < NUM_REQ; i++) begin
            setPort(i, WIDTH'(i*16 + 1), 32'd100, TAG_W'(i + 8));
        end
    endtask

    initial begin
        vecs[0] = '{port: 0, a: 32'd5,          b: 32'd7,          tag: 5'd3,  sum: 32'd12};
        vecs[1] = '{port: 0, a: 32'hFFFF_FFFF, b: 32'h0000_0001, tag: 5'd4,  sum: 32'h0000_0000};
        vecs[2] = '{port: 1, a: 32'h8000_0000, b: 32'h8000_0000, tag: 5'd17, sum: 32'h0000_0000};
        vecs[3] = '{port: 2, a: 32'h7FFF_FFFF, b: 32'h0000_0001, tag: 5'd31, sum: 32'h8000_0000};
        vecs[4] = '{port: 1, a: 32'h0000_0000, b: 32'h0000_0000, tag: 5'd0,  sum: 32'h0000_0000};
        vecs[5] = '{port: 3, a: 32'h1234_5678, b: 32'h1111_1111, tag: 5'd9,  sum: 32'h2345_6789};

        rst_n     = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;
        flush     = 1'b0;
        cdb_ready = 1'b1;

        // Reset state, with requests present to show the grant is held off
        #12;
        checkOutput("reset req_ready", req_ready, 0);
        checkOutput("reset cdb_valid", cdb_valid, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset inflight", inflight, 0);
        checkOutput("reset add_a", add_a, 0);
        checkOutput("reset cdb_result", cdb_result, 0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();

        // Single-op vectors: latency, arithmetic wrap, tag and source
        for (int v = 0; v < 6; v++) begin
            setPort(vecs[v].port, vecs[v].a, vecs[v].b, vecs[v].tag);
            applyStimulus(NUM_REQ'(1 << vecs[v].port), 1'b1, 1'b0);
            checkOutput("vec req_ready", req_ready, 64'(1 << vecs[v].port));
            nextCycle();
            req_valid = '0;
            #1;
            checkOutput("vec add_a", add_a, vecs[v].a);
            checkOutput("vec early cdb_valid", cdb_valid, 0);
            nextCycle();
            checkOutput("vec cdb_valid", cdb_valid, 1);
            checkOutput("vec cdb_result", cdb_result, vecs[v].sum);
            checkOutput("vec cdb_tag", cdb_tag, vecs[v].tag);
            checkOutput("vec cdb_src", cdb_src, vecs[v].port);
            nextCycle();
            checkOutput("vec drained", cdb_valid, 0);
        end

        // All ports valid continuously: grants rotate 0,1,2,3,0,...
        loadStreamData();
        for (int n = 0; n < 9; n++) begin
            applyStimulus((n < 7) ? 4'hF : 4'h0, 1'b1, 1'b0);
            checkOutput("rr req_ready", req_ready, (n < 7) ? 64'(1 << (n % 4)) : 64'd0);
            if (n >= 2) begin
                checkOutput("rr cdb_valid", cdb_valid, 1);
                checkOutput("rr cdb_src", cdb_src, (n - 2) % 4);
                checkOutput("rr cdb_result", cdb_result, ((n - 2) % 4) * 16 + 1 + 100);
                checkOutput("rr cdb_tag", cdb_tag, ((n - 2) % 4) + 8);
            end
            nextCycle();
        end
        checkOutput("rr drained", cdb_valid, 0);

        // Backpressure: fill the pipe, stall three cycles, then drain in order
        applyStimulus(4'hF, 1'b0, 1'b0);
        checkOutput("stall first grant", req_ready, 64'h8);
        nextCycle();
        applyStimulus(4'hF, 1'b0, 1'b0);
        checkOutput("stall second grant", req_ready, 64'h1);
        checkOutput("stall pre cdb_valid", cdb_valid, 0);
        nextCycle();
        for (int n = 0; n < 3; n++) begin
            applyStimulus(4'hF, 1'b0, 1'b0);
            checkOutput("stall req_ready", req_ready, 0);
            checkOutput("stall cdb_valid", cdb_valid, 1);
            checkOutput("stall cdb_src", cdb_src, 3);
            checkOutput("stall cdb_result", cdb_result, 3*16 + 1 + 100);
            checkOutput("stall inflight", inflight, 2);
            nextCycle();
        end
        applyStimulus(4'h0, 1'b1, 1'b0);
        checkOutput("release cdb_src", cdb_src, 3);
        nextCycle();
        checkOutput("release second valid", cdb_valid, 1);
        checkOutput("release second src", cdb_src, 0);
        checkOutput("release second result", cdb_result, 101);
        checkOutput("release inflight", inflight, 1);
        nextCycle();
        checkOutput("release drained", cdb_valid, 0);
        checkOutput("release inflight zero", inflight, 0);

        // Flush with two in flight and port 1 requesting
        applyStimulus(4'h4, 1'b1, 1'b0);
        checkOutput("flush fill a", req_ready, 64'h4);
        nextCycle();
        applyStimulus(4'h8, 1'b1, 1'b0);
        checkOutput("flush fill b", req_ready, 64'h8);
        nextCycle();
        applyStimulus(4'h2, 1'b1, 1'b1);
        checkOutput("flush req_ready", req_ready, 0);
        checkOutput("flush inflight before", inflight, 2);
        checkOutput("flush cdb_src", cdb_src, 2);
        nextCycle();
        applyStimulus(4'hA, 1'b1, 1'b0);
        checkOutput("post flush busy", busy, 0);
        checkOutput("post flush cdb_valid", cdb_valid, 0);
        checkOutput("post flush inflight", inflight, 0);
        checkOutput("post flush grant", req_ready, 64'h2);
        nextCycle();
        applyStimulus(4'h0, 1'b1, 1'b0);
        checkOutput("post flush gap", cdb_valid, 0);
        nextCycle();
        checkOutput("post flush result valid", cdb_valid, 1);
        checkOutput("post flush result src", cdb_src, 1);
        checkOutput("post flush result", cdb_result, 117);
        nextCycle();

        // Asynchronous reset in the middle of a busy stream
        applyStimulus(4'hF, 1'b1, 1'b0);
        nextCycle();
        nextCycle();
        nextCycle();
        checkOutput("pre reset cdb_valid", cdb_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async cdb_valid", cdb_valid, 0);
        checkOutput("async busy", busy, 0);
        checkOutput("async inflight", inflight, 0);
        checkOutput("async req_ready", req_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("reset first grant", req_ready, 64'h1);
        nextCycle();
        applyStimulus(4'hF, 1'b1, 1'b0);
        checkOutput("reset second grant", req_ready, 64'h2);
        applyStimulus(4'h0, 1'b1, 1'b0);
        nextCycle();
        nextCycle();
        nextCycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
